// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: burst/response encodings and
// the read arbiter state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BEAT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } axi_rd_arb_state_t;

endpackage

// File: rtl/axi_rd_if.sv
// AXI read channels (AR + R) bundled with target/initiator views.
// r_target is the subordinate side, r_init the manager side.
interface axi_rd_if #(
    parameter int ARADDR_W = 32,
    parameter int RDATA_W  = 128
);
    logic                ARVALID;
    logic                ARREADY;
    logic [ARADDR_W-1:0] ARADDR;
    logic [1:0]          ARBURST;
    logic [7:0]          ARLEN;
    logic                RVALID;
    logic                RREADY;
    logic [RDATA_W-1:0]  RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;

    modport r_target (
        input  ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST
    );

    modport r_init (
        output ARVALID, ARADDR, ARBURST, ARLEN, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping. Shared by the read arbiter and the future write arbiter.
module rr_arbiter #(
    parameter  int N_INIT = 4,
    localparam int IDX_W  = $clog2(N_INIT)
) (
    input  logic [N_INIT-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [N_INIT-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [N_INIT-1:0] rot;
    logic [IDX_W-1:0]  off;
    logic [IDX_W:0]    sum;
    logic              hit;

    // rotate so ptr sits at bit 0, find lowest set bit, rotate back
    always_comb begin
        rot = N_INIT'({req, req} >> ptr);
        off = '0;
        hit = 1'b0;
        for (int k = N_INIT - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
                hit = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_INIT)) begin
            sum = sum - (IDX_W+1)'(N_INIT);
        end
        gnt_idx = sum[IDX_W-1:0];
        for (int i = 0; i < N_INIT; i++) begin
            gnt[i] = hit && (gnt_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// N-initiator AXI read arbiter, one burst in flight, with burst-length check.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module axi_rd_arb #(
    parameter  int N_INIT   = 4,
    parameter  int ARADDR_W = 32,
    parameter  int RDATA_W  = 128,
    localparam int IDX_W    = $clog2(N_INIT)
) (
    input  logic             CLK,
    input  logic             RSTn,
    axi_rd_if.r_target       s_axi [N_INIT],
    axi_rd_if.r_init         m_axi,
    output logic [IDX_W-1:0] GRANT_IDX,
    output logic             BUSY,
    output logic             LEN_ERR
);
    import axi_pkg::*;

    axi_rd_arb_state_t state;
    axi_rd_arb_state_t state_nxt;

    logic [N_INIT-1:0]     req;
    logic [N_INIT-1:0]     win_gnt;
    logic [N_INIT-1:0]     rready_v;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      grant;
    logic [ARADDR_W-1:0]   addr_v  [N_INIT];
    logic [1:0]            burst_v [N_INIT];
    logic [7:0]            len_v   [N_INIT];
    logic [ARADDR_W-1:0]   req_addr;
    logic [1:0]            req_burst;
    logic [7:0]            req_len;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic                  len_err;
    logic                  in_idle;
    logic                  in_addr;
    logic                  in_data;
    logic                  ar_take;
    logic                  r_hs;
    logic                  last_hs;

    for (genvar i = 0; i < N_INIT; i++) begin : g_port
        logic sel;
        assign sel        = in_data && (grant == IDX_W'(i));
        assign req[i]     = s_axi[i].ARVALID;
        assign addr_v[i]  = s_axi[i].ARADDR;
        assign burst_v[i] = s_axi[i].ARBURST;
        assign len_v[i]   = s_axi[i].ARLEN;
        assign rready_v[i] = s_axi[i].RREADY;
        // ARREADY is gated by reset so a requester never sees it while held
        assign s_axi[i].ARREADY = RSTn && in_idle && win_gnt[i];
        assign s_axi[i].RVALID  = sel && m_axi.RVALID;
        assign s_axi[i].RDATA   = sel ? m_axi.RDATA : '0;
        assign s_axi[i].RRESP   = sel ? m_axi.RRESP : '0;
        assign s_axi[i].RLAST   = sel && m_axi.RLAST;
    end

    rr_arbiter #(
        .N_INIT (N_INIT)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (win_gnt),
        .gnt_idx (win_idx)
    );

    assign ar_take = in_idle && (|req);
    assign r_hs    = in_data && m_axi.RVALID && m_axi.RREADY;
    assign last_hs = r_hs && m_axi.RLAST;

    // state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req)          state_nxt = ADDR;
            ADDR:    if (m_axi.ARREADY) state_nxt = DATA;
            DATA:    if (last_hs)       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // state decode for the datapath and outputs
    always_comb begin
        in_idle = 1'b0;
        in_addr = 1'b0;
        in_data = 1'b0;
        unique case (state)
            IDLE:    in_idle = 1'b1;
            ADDR:    in_addr = 1'b1;
            DATA:    in_data = 1'b1;
            default: in_idle = 1'b1;
        endcase
    end

    // capture the winner's request and identity on acceptance
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            req_addr  <= '0;
            req_burst <= '0;
            req_len   <= '0;
            grant     <= '0;
        end else if (ar_take) begin
            req_addr  <= addr_v[win_idx];
            req_burst <= burst_v[win_idx];
            req_len   <= len_v[win_idx];
            grant     <= win_idx;
        end
    end

    // saturating beat counter for the burst in flight
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                          beat_cnt <= '0;
        else if (ar_take)                   beat_cnt <= '0;
        else if (r_hs && (&beat_cnt) == 1'b0) beat_cnt <= beat_cnt + 1'b1;
    end

    // sticky length error: wrong count at RLAST, or counter overrun
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            len_err <= 1'b0;
        end else if (r_hs) begin
            if (m_axi.RLAST && beat_cnt != req_len) len_err <= 1'b1;
            if (!m_axi.RLAST && (&beat_cnt))        len_err <= 1'b1;
        end
    end

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // rotate the search start past the initiator that just finished
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr <= '0;
        end else if (last_hs) begin
            ptr <= (grant == IDX_W'(N_INIT - 1)) ? '0 : grant + IDX_W'(1);
        end
    end
`endif

    assign m_axi.ARVALID = in_addr;
    assign m_axi.ARADDR  = req_addr;
    assign m_axi.ARBURST = req_burst;
    assign m_axi.ARLEN   = req_len;
    assign m_axi.RREADY  = in_data && rready_v[grant];

    assign GRANT_IDX = grant;
    assign BUSY      = !in_idle;
    assign LEN_ERR   = len_err;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model.
module tb_axi_rd_arb;
    import axi_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rd_if #(.ARADDR_W(AW), .RDATA_W(DW)) s_if [N] ();
    axi_rd_if #(.ARADDR_W(AW), .RDATA_W(DW)) m_if ();

    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          len_err;

    axi_rd_arb #(.N_INIT(N), .ARADDR_W(AW), .RDATA_W(DW)) dut (
        .CLK       (clk),
        .RSTn      (rst_n),
        .s_axi     (s_if),
        .m_axi     (m_if),
        .GRANT_IDX (grant_idx),
        .BUSY      (busy),
        .LEN_ERR   (len_err)
    );

    logic          arvalid [N];
    logic [AW-1:0] araddr  [N];
    logic [1:0]    arburst [N];
    logic [7:0]    arlen   [N];
    logic          rready  [N];
    logic          arready_o [N];
    logic          rvalid_o  [N];
    logic [DW-1:0] rdata_o   [N];
    logic [1:0]    rresp_o   [N];
    logic          rlast_o   [N];

    for (genvar i = 0; i < N; i++) begin : g_up
        assign s_if[i].ARVALID = arvalid[i];
        assign s_if[i].ARADDR  = araddr[i];
        assign s_if[i].ARBURST = arburst[i];
        assign s_if[i].ARLEN   = arlen[i];
        assign s_if[i].RREADY  = rready[i];
        assign arready_o[i] = s_if[i].ARREADY;
        assign rvalid_o[i]  = s_if[i].RVALID;
        assign rdata_o[i]   = s_if[i].RDATA;
        assign rresp_o[i]   = s_if[i].RRESP;
        assign rlast_o[i]   = s_if[i].RLAST;
    end

    logic          t_arready;
    logic          t_rvalid;
    logic          t_rlast;
    logic [DW-1:0] t_rdata;
    logic [1:0]    t_rresp;
    assign m_if.ARREADY = t_arready;
    assign m_if.RVALID  = t_rvalid;
    assign m_if.RDATA   = t_rdata;
    assign m_if.RRESP   = t_rresp;
    assign m_if.RLAST   = t_rlast;

    int checks = 0;
    int failures = 0;

    // model: phase 0 idle, 1 address out, 2 data
    int         ph, mg, mptr, mbeats;
    logic [AW-1:0] maddr;
    logic [1:0] mburst;
    logic [7:0] mlen;
    logic       merr;

    bit rand_mode;
    bit auto_req [N];
    bit toggle_rr [N];
    int beats_rx [N];
    int grant_log [$];
    int arready_pct, rvalid_pct, tgt_mode, req_len_max;
    bit t_pending;
    int t_left;
    bit up_hs [N];
    bit m_ar_hs, m_r_hs;
    logic [7:0] m_len_cap;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        ph = 0; mg = 0; mptr = 0; mbeats = 0;
        maddr = '0; mburst = '0; mlen = '0; merr = 1'b0;
    endfunction

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (arvalid[j]) return j;
        end
        return -1;
    endfunction

    task automatic check_and_step();
        int w;
        bit sel;
        if (!rst_n) model_reset();
        w = (ph == 0 && rst_n) ? winner() : -1;
        for (int i = 0; i < N; i++) begin
            sel = (ph == 2) && (mg == i);
            chk($sformatf("arready[%0d]", i), arready_o[i], w == i);
            chk($sformatf("rvalid[%0d]", i), rvalid_o[i], sel && t_rvalid);
            chk($sformatf("rdata[%0d]", i), rdata_o[i], sel ? t_rdata : '0);
            chk($sformatf("rresp[%0d]", i), rresp_o[i], sel ? t_rresp : 2'b00);
            chk($sformatf("rlast[%0d]", i), rlast_o[i], sel && t_rlast);
        end
        chk("m_arvalid", m_if.ARVALID, ph == 1);
        chk("m_araddr", m_if.ARADDR, maddr);
        chk("m_arburst", m_if.ARBURST, mburst);
        chk("m_arlen", m_if.ARLEN, mlen);
        chk("m_rready", m_if.RREADY, (ph == 2) && rready[mg]);
        chk("grant_idx", grant_idx, mg);
        chk("busy", busy, ph != 0);
        chk("len_err", len_err, merr);
        for (int i = 0; i < N; i++) begin
            up_hs[i] = arvalid[i] && arready_o[i];
            if (up_hs[i] && rst_n) grant_log.push_back(i);
            if (rvalid_o[i] && rready[i]) beats_rx[i]++;
        end
        m_ar_hs = m_if.ARVALID && t_arready;
        m_r_hs = t_rvalid && m_if.RREADY;
        m_len_cap = m_if.ARLEN;
        if (rst_n) begin
            case (ph)
                0: if (w >= 0) begin
                    mg = w; maddr = araddr[w]; mburst = arburst[w];
                    mlen = arlen[w]; mbeats = 0; ph = 1;
                end
                1: if (t_arready) ph = 2;
                default: if (t_rvalid && rready[mg]) begin
                    mbeats++;
                    if (t_rlast) begin
                        if (mbeats != int'(mlen) + 1) merr = 1'b1;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
                        mptr = 0;
`else
                        mptr = (mg + 1) % N;
`endif
                        ph = 0;
                    end else if (mbeats >= 256) begin
                        merr = 1'b1;
                    end
                end
            endcase
        end
    endtask

    task automatic new_req(input int i);
        arvalid[i] = 1'b1;
        araddr[i]  = $urandom;
        arburst[i] = 2'($urandom_range(2));
        arlen[i]   = 8'($urandom_range(req_len_max));
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        arvalid[i] = 1'b1;
        araddr[i]  = a;
        arburst[i] = BURST_INCR;
        arlen[i]   = l;
    endtask

    task automatic drive();
        int mode, r;
        if (m_r_hs) begin
            t_left--;
            if (t_left <= 0) t_pending = 1'b0;
            t_rvalid = 1'b0;
        end
        if (m_ar_hs) begin
            mode = tgt_mode;
            if (mode == 3) begin
                r = $urandom_range(9);
                mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            end
            t_pending = 1'b1;
            t_left = int'(m_len_cap) + 1;
            if (mode == 1) t_left = (m_len_cap > 0) ? int'(m_len_cap) : 2;
            if (mode == 2) t_left = int'(m_len_cap) + 2;
        end
        if (t_pending && !t_rvalid && $urandom_range(99) < rvalid_pct) begin
            t_rvalid = 1'b1;
            t_rdata  = {$urandom, $urandom, $urandom, $urandom};
            t_rresp  = 2'($urandom_range(3));
            t_rlast  = (t_left == 1);
        end
        if (!t_rvalid) t_rlast = 1'b0;
        t_arready = ($urandom_range(99) < arready_pct);
        for (int i = 0; i < N; i++) begin
            if (up_hs[i]) begin
                if (auto_req[i]) new_req(i);
                else arvalid[i] = 1'b0;
            end
            if (rand_mode) begin
                if (!arvalid[i] && $urandom_range(99) < 15) new_req(i);
                else if (arvalid[i] && !up_hs[i] && $urandom_range(99) < 3) arvalid[i] = 1'b0;
                rready[i] = ($urandom_range(99) < 75);
            end else if (toggle_rr[i]) begin
                rready[i] = !rready[i];
            end else begin
                rready[i] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        t_pending = 1'b0; t_rvalid = 1'b0; t_rlast = 1'b0; t_arready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_m_arvalid", m_if.ARVALID, 0);
        chk("rst_m_rready", m_if.RREADY, 0);
        chk("rst_m_araddr", m_if.ARADDR, 0);
        chk("rst_m_arlen", m_if.ARLEN, 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_arready[%0d]", i), arready_o[i], 0);
            chk($sformatf("rst_rvalid[%0d]", i), rvalid_o[i], 0);
            chk($sformatf("rst_rdata[%0d]", i), rdata_o[i], 0);
        end
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        cycle();
        while (busy && n < lim) begin
            cycle();
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", lim);
        end
    endtask

    task automatic clear_rx();
        for (int i = 0; i < N; i++) beats_rx[i] = 0;
    endtask

    initial begin
        int n;
        int exp_order [5];
        for (int i = 0; i < N; i++) begin
            arvalid[i] = 1'b0; araddr[i] = '0; arburst[i] = '0; arlen[i] = '0;
            rready[i] = 1'b1; auto_req[i] = 1'b0; toggle_rr[i] = 1'b0;
            up_hs[i] = 1'b0; beats_rx[i] = 0;
        end
        t_arready = 1'b0; t_rvalid = 1'b0; t_rlast = 1'b0;
        t_rdata = '0; t_rresp = '0; t_pending = 1'b0; t_left = 0;
        m_ar_hs = 1'b0; m_r_hs = 1'b0; m_len_cap = '0;
        rand_mode = 1'b0; tgt_mode = 0; req_len_max = 7;
        arready_pct = 100; rvalid_pct = 100;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // single initiator, 4-beat burst
        clear_rx();
        set_req(2, 32'h1000, 8'd3);
        #1;
        chk("t1_arready2", arready_o[2], 1);
        chk("t1_arready0", arready_o[0], 0);
        cycle();
        #1;
        chk("t1_m_arvalid", m_if.ARVALID, 1);
        chk("t1_m_araddr", m_if.ARADDR, 32'h1000);
        chk("t1_grant", grant_idx, 2);
        wait_idle(50);
        chk("t1_beats2", beats_rx[2], 4);
        chk("t1_beats0", beats_rx[0], 0);
        chk("t1_len_err", len_err, 0);

        // all initiators requesting continuously, single-beat bursts
        do_reset();
        req_len_max = 0;
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            auto_req[i] = 1'b1;
            new_req(i);
        end
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            cycle();
            n++;
        end
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_grant%0d", k),
                (k < grant_log.size()) ? grant_log[k] : 99, exp_order[k]);
        end
        for (int i = 0; i < N; i++) begin
            auto_req[i] = 1'b0;
            arvalid[i] = 1'b0;
        end
        wait_idle(100);
        req_len_max = 7;

        // RREADY backpressure on an 8-beat burst
        clear_rx();
        set_req(1, 32'h2000, 8'd7);
        toggle_rr[1] = 1'b1;
        wait_idle(100);
        toggle_rr[1] = 1'b0;
        chk("t3_beats1", beats_rx[1], 8);

        // early RLAST sets the sticky error
        clear_rx();
        tgt_mode = 1;
        set_req(0, 32'h3000, 8'd3);
        wait_idle(100);
        chk("t4_len_err", len_err, 1);
        chk("t4_beats0", beats_rx[0], 3);
        tgt_mode = 0;
        set_req(1, 32'h3100, 8'd1);
        wait_idle(100);
        chk("t4_len_err_sticky", len_err, 1);
        chk("t4_beats1", beats_rx[1], 2);

        // downstream ARREADY held low
        arready_pct = 0;
        set_req(3, 32'hABCD0, 8'd5);
        repeat (6) cycle();
        chk("t5_araddr", m_if.ARADDR, 32'hABCD0);
        chk("t5_arlen", m_if.ARLEN, 5);
        chk("t5_arvalid", m_if.ARVALID, 1);
        arready_pct = 100;
        wait_idle(100);

        // reset in the middle of a data burst
        clear_rx();
        set_req(2, 32'h4000, 8'd3);
        n = 0;
        while (beats_rx[2] < 1 && n < 20) begin
            cycle();
            n++;
        end
        chk("t6_first_beat", beats_rx[2], 1);
        do_reset();
        set_req(3, 32'h5000, 8'd0);
        set_req(1, 32'h5100, 8'd0);
        #1;
        chk("t6_arready1", arready_o[1], 1);
        chk("t6_arready3", arready_o[3], 0);
        wait_idle(50);

        // randomized traffic
        rand_mode = 1'b1;
        tgt_mode = 3;
        arready_pct = 70;
        rvalid_pct = 70;
        for (int c = 0; c < 4000; c++) begin
            cycle();
            if (c == 1500 || c == 3000) do_reset();
        end
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) arvalid[i] = 1'b0;
        arready_pct = 100;
        rvalid_pct = 100;
        wait_idle(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
